clk_div_prog: RTL

//   Runtime-programmable clock divider / pulse generator, a parametrised successor to the fixed

---
 rtl/clk_div_prog.sv | 133 +++++++++++++
 1 files changed

// File: rtl/clk_div_prog.sv
// Programmable clock divider / pulse generator with glitch-free
// config updates at period boundaries.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   en                : run request, sampled every edge
//   cfg_valid/ready   : config handshake (ready = no config pending)
//   cfg_div, cfg_high : period and high-time in cycles
//   clk_out           : registered divided output
//   period_start      : 1-cycle pulse with each period's first output
//   running           : high while in RUN
module clk_div_prog #(
  parameter int CNT_W        = 8,
  parameter int DEFAULT_DIV  = 4,
  parameter int DEFAULT_HIGH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             period_start,
  output logic             running
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIV0  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] HIGH0 = CNT_W'(DEFAULT_HIGH);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] high_act;
  logic [CNT_W-1:0] sh_div;
  logic [CNT_W-1:0] sh_high;
  logic [CNT_W-1:0] high_use;
  logic             pending;
  logic             accept;
  logic             apply;
  logic             wrap;
  logic             clk_out_d;
  logic             ps_d;

  assign cfg_ready = ~pending;
  assign running   = (state == RUN);
  assign accept    = cfg_valid & ~pending;
  assign wrap      = (state == RUN) && (cnt == div_act - ONE);
  // pending is the pre-edge value, so an accept never applies
  // on its own edge.
  assign apply     = pending & ((state == IDLE) | wrap);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (en) state_d = RUN;
      RUN:  if (wrap && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt;
    clk_out_d = 1'b0;
    ps_d      = 1'b0;
    // A period launched from IDLE already uses a config
    // applied on that same edge.
    high_use  = apply ? sh_high : high_act;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (en) begin
          clk_out_d = (high_use != '0);
          ps_d      = 1'b1;
          cnt_d     = ONE;
        end
      end
      RUN: begin
        clk_out_d = (cnt < high_act);
        ps_d      = (cnt == '0);
        cnt_d     = wrap ? '0 : cnt + ONE;
        if (wrap && !en) begin
          clk_out_d = 1'b0;
          ps_d      = 1'b0;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      clk_out      <= 1'b0;
      period_start <= 1'b0;
      pending      <= 1'b0;
      div_act      <= DIV0;
      high_act     <= HIGH0;
      sh_div       <= DIV0;
      sh_high      <= HIGH0;
    end else begin
      cnt          <= cnt_d;
      clk_out      <= clk_out_d;
      period_start <= ps_d;
      if (apply) begin
        div_act  <= sh_div;
        high_act <= sh_high;
        pending  <= 1'b0;
      end
      if (accept) begin
        sh_div  <= (cfg_div < TWO) ? TWO : cfg_div;
        sh_high <= cfg_high;
        pending <= 1'b1;
      end
    end
  end

endmodule
